// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RISC-V byte/half/word load-store sequencer; misaligned
//               accesses that cross a word boundary become two word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_AW = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC0 = 2'd1;
    localparam logic [1:0] c_ACC1 = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_we;
    logic [2:0]        r_func3;
    logic [1:0]        r_off;
    logic [MEM_AW-1:0] r_word;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word0;

    logic              w_legal;
    logic [2:0]        w_size;
    logic [3:0]        w_mask4;
    logic [7:0]        w_strb8;
    logic [63:0]       w_wdata64;
    logic              w_split;
    logic [63:0]       w_pair;
    logic [31:0]       w_ld_word;
    logic              w_sign;
    logic [31:0]       w_load;
    logic              w_unused_addr;

    function automatic logic f_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        return (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
    endfunction

    // Address bits above the memory's word range are intentionally ignored.
    assign w_unused_addr = ^req_addr[31:MEM_AW+2];

    assign req_ready = (r_state == c_IDLE);
    assign w_legal   = f_legal(r_we, r_func3);

    always_comb begin
        w_size  = 3'd4;
        w_mask4 = 4'b1111;
        case (r_func3[1:0])
            2'b00:   begin w_size = 3'd1; w_mask4 = 4'b0001; end
            2'b01:   begin w_size = 3'd2; w_mask4 = 4'b0011; end
            default: begin w_size = 3'd4; w_mask4 = 4'b1111; end
        endcase
    end

    assign w_split   = ({1'b0, r_off} + w_size) > 3'd4;
    assign w_strb8   = {4'b0000, w_mask4} << r_off;
    assign w_wdata64 = {32'd0, r_wdata} << {r_off, 3'b000};

    // Unsplit loads see their only word live in DONE; split loads pair it with word0.
    assign w_pair    = w_split ? {mem_rdata, r_word0} : {32'd0, mem_rdata};
    assign w_ld_word = w_pair[{r_off, 3'b000} +: 32];
    assign w_sign    = ~r_func3[2];

    always_comb begin
        w_load = w_ld_word;
        case (r_func3[1:0])
            2'b00:   w_load = {{24{w_sign & w_ld_word[7]}}, w_ld_word[7:0]};
            2'b01:   w_load = {{16{w_sign & w_ld_word[15]}}, w_ld_word[15:0]};
            default: w_load = w_ld_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_we    <= 1'b0;
            r_func3 <= 3'd0;
            r_off   <= 2'd0;
            r_word  <= '0;
            r_wdata <= 32'd0;
            r_word0 <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_func3 <= req_func3;
                        r_off   <= req_addr[1:0];
                        r_word  <= req_addr[MEM_AW+1:2];
                        r_wdata <= req_wdata;
                        r_state <= f_legal(req_we, req_func3) ? c_ACC0 : c_DONE;
                    end
                end
                c_ACC0: r_state <= w_split ? c_ACC1 : c_DONE;
                c_ACC1: begin
                    r_word0 <= mem_rdata;
                    r_state <= c_DONE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'd0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        case (r_state)
            c_ACC0: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_word;
                mem_wstrb = r_we ? w_strb8[3:0] : 4'b0000;
                mem_wdata = w_wdata64[31:0];
            end
            c_ACC1: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_word + MEM_AW'(1);
                mem_wstrb = r_we ? w_strb8[7:4] : 4'b0000;
                mem_wdata = w_wdata64[63:32];
            end
            c_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = ~w_legal;
                rsp_rdata = (w_legal && !r_we) ? w_load : 32'd0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed plus randomized bench for load_store_unit against a
//               byte-addressed reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam logic [31:0] c_WMASK = 32'h00FF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dmem [int];
    logic [31:0] refm [int];

    int          obs_n;
    logic [23:0] obs_addr  [2];
    logic        obs_we    [2];
    logic [3:0]  obs_strb  [2];
    logic [31:0] obs_wdata [2];

    load_store_unit #(.MEM_AW(24)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        logic [31:0] x;
        x = 32'(w);
        return (x * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] dmem_rd(input int w);
        return dmem.exists(w) ? dmem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] refm_rd(input int w);
        return refm.exists(w) ? refm[w] : init_word(w);
    endfunction

    function automatic int word_of(input logic [31:0] b);
        return int'((b >> 2) & c_WMASK);
    endfunction

    // Drives one request and follows it to completion, acting as the memory.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic err, output int lat);
        logic        pend;
        int          pa;
        logic [31:0] w;
        pend = 1'b0;
        pa   = 0;
        rd   = 32'd0;
        err  = 1'b0;
        @(negedge clk);
        chk("idle_ready", {63'd0, req_ready}, 64'd1);
        chk("idle_no_rsp", {63'd0, rsp_valid}, 64'd0);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = $urandom_range(0, 1); req_func3 = 3'($urandom); req_addr = $urandom;
        obs_n = 0;
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            if (mem_en) begin
                if (obs_n < 2) begin
                    obs_addr[obs_n]  = mem_addr;
                    obs_we[obs_n]    = mem_we;
                    obs_strb[obs_n]  = mem_wstrb;
                    obs_wdata[obs_n] = mem_wdata;
                end
                obs_n++;
                if (mem_we) begin
                    w = dmem_rd(int'(mem_addr));
                    for (int i = 0; i < 4; i++)
                        if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                    dmem[int'(mem_addr)] = w;
                end else begin
                    pend = 1'b1;
                    pa   = int'(mem_addr);
                end
            end
            @(posedge clk);
            #1;
            if (pend) begin
                mem_rdata = dmem_rd(pa);
                pend = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        rd  = rsp_rdata;
        err = rsp_err;
        chk("done_mem_quiet", {7'd0, mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata}, 64'd0);
    endtask

    // Reference: walks the access one byte at a time over a byte-addressed memory.
    task automatic check_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input logic err, input int lat);
        logic        legal;
        int          n, o, nacc, exp_lat, idx, lane, w;
        logic [3:0]  exp_strb [2];
        logic [31:0] exp_wd   [2];
        logic [31:0] bmask, val, word, b;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        o    = int'(a[1:0]);
        nacc = !legal ? 0 : ((o + n > 4) ? 2 : 1);
        exp_lat = !legal ? 1 : nacc + 1;
        exp_strb[0] = 4'd0; exp_strb[1] = 4'd0;
        exp_wd[0] = 32'd0;  exp_wd[1] = 32'd0;
        val = 32'd0;
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                b    = a + 32'(k);
                idx  = (o + k) / 4;
                lane = int'(b[1:0]);
                w    = word_of(b);
                word = refm_rd(w);
                if (we) begin
                    exp_strb[idx][lane] = 1'b1;
                    exp_wd[idx][8*lane +: 8] = wd[8*k +: 8];
                    word[8*lane +: 8] = wd[8*k +: 8];
                    refm[w] = word;
                end else begin
                    val[8*k +: 8] = word[8*lane +: 8];
                end
            end
            if (!we && f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
            if (!we && f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
            if (we) val = 32'd0;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_err", {63'd0, err}, {63'd0, ~legal});
        chk("rsp_rdata", {32'd0, rd}, {32'd0, val});
        chk("n_access", 64'(obs_n), 64'(nacc));
        for (int i = 0; i < nacc; i++) begin
            chk("acc_addr", {40'd0, obs_addr[i]}, 64'(((a >> 2) + 32'(i)) & c_WMASK));
            chk("acc_we", {63'd0, obs_we[i]}, {63'd0, we});
            chk("acc_strb", {60'd0, obs_strb[i]}, {60'd0, exp_strb[i]});
            bmask = {{8{exp_strb[i][3]}}, {8{exp_strb[i][2]}}, {8{exp_strb[i][1]}}, {8{exp_strb[i][0]}}};
            if (we) chk("acc_wdata", {32'd0, obs_wdata[i] & bmask}, {32'd0, exp_wd[i]});
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
        logic err;
        int   lat;
        run_req(we, f3, a, wd, rd, err, lat);
        check_txn(we, f3, a, wd, rd, err, lat);
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        dmem[w] = v;
        refm[w] = v;
    endtask

    initial begin
        logic [31:0] rd;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        chk("rst_mem", {7'd0, mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata}, 64'd0);

        txn(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, rd);
        chk("sw_addr", {40'd0, obs_addr[0]}, 64'h40);
        chk("sw_strb", {60'd0, obs_strb[0]}, 64'hF);
        chk("sw_wdata", {32'd0, obs_wdata[0]}, 64'hDEAD_BEEF);

        preload(32'h40, 32'h8011_2233);
        txn(1'b0, 3'd0, 32'h103, 32'd0, rd);
        chk("lb_sext", {32'd0, rd}, 64'hFFFF_FF80);
        txn(1'b0, 3'd4, 32'h103, 32'd0, rd);
        chk("lbu_zext", {32'd0, rd}, 64'h0000_0080);

        preload(32'h40, 32'hAB00_0000);
        preload(32'h41, 32'h0000_00CD);
        txn(1'b0, 3'd1, 32'h103, 32'd0, rd);
        chk("lh_split", {32'd0, rd}, 64'hFFFF_CDAB);
        chk("lh_addr1", {40'd0, obs_addr[1]}, 64'h41);

        txn(1'b1, 3'd2, 32'h102, 32'h1122_3344, rd);
        chk("sws_strb0", {60'd0, obs_strb[0]}, 64'hC);
        chk("sws_wd0", {32'd0, obs_wdata[0]}, 64'h3344_0000);
        chk("sws_strb1", {60'd0, obs_strb[1]}, 64'h3);
        chk("sws_wd1", {32'd0, obs_wdata[1]}, 64'h0000_1122);

        txn(1'b0, 3'd5, 32'h03FF_FFFF, 32'd0, rd);
        chk("wrap_addr0", {40'd0, obs_addr[0]}, 64'hFF_FFFF);
        chk("wrap_addr1", {40'd0, obs_addr[1]}, 64'h0);
        txn(1'b0, 3'd3, 32'h100, 32'd0, rd);
        txn(1'b1, 3'd5, 32'h104, 32'h55, rd);

        // Abort a split load in its second access.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'd1; req_addr = 32'h103;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_acc0", {40'd0, mem_addr}, 64'h40);
        @(negedge clk);
        chk("abort_acc1", {40'd0, mem_addr}, 64'h41);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {61'd0, req_ready, rsp_valid, mem_en}, 64'b100);
        @(negedge clk);
        chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        preload(32'h40, 32'h8011_2233);
        txn(1'b0, 3'd2, 32'h100, 32'd0, rd);
        chk("lw_after_abort", {32'd0, rd}, 64'h8011_2233);

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 31));
            txn(we, f3, a, $urandom, rd);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 24: word-address width of the data memory (2^MEM_AW words).
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset.
- req_valid  in  1  pipeline presents a memory request.
- req_ready  out  1  LSU accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 access type.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  MEM_AW  word address.
- mem_wstrb  out  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read word, valid the cycle after mem_en.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_err  out  1  illegal access type; qualified by rsp_valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.

Function
REQ-003 SHALL implement states IDLE, ACC0, ACC1, DONE; req_ready=1 only in IDLE.
REQ-004 SHALL accept a request when req_valid&&req_ready at edge T and latch we, func3, addr, wdata.
REQ-005 SHALL decode legal loads as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, and legal stores as 000 SB, 001 SH, 010 SW; size n = 1/2/4 bytes.
REQ-006 SHALL treat any other func3 as illegal: IDLE->DONE, never assert mem_en, and in DONE assert rsp_err=1, rsp_rdata=0.
REQ-007 SHALL compute offset o=addr[1:0] and word W=addr[MEM_AW+1:2], and split an access iff o+n>4.
REQ-008 SHALL, in ACC0, drive mem_en=1, mem_we=we, mem_addr=W, mem_wstrb=(lane mask of n bytes << o)[3:0], and mem_wdata=(wdata<<8o)[31:0].
REQ-009 SHALL go ACC0->ACC1 if the access is split, else ACC0->DONE.
REQ-010 SHALL, in ACC1, drive mem_addr=W+1 modulo 2^MEM_AW, mem_wstrb=(mask<<o)[7:4], and mem_wdata=(wdata<<8o)[63:32]; it SHALL also capture mem_rdata as word0.
REQ-011 SHALL, in DONE, assert rsp_valid=1 for exactly one cycle and then return to IDLE.
REQ-012 SHALL form load data as ({word1,word0}>>8o) truncated to n bytes, where word0/word1 are mem_rdata in DONE (word0 only when unsplit); it SHALL sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-013 SHALL drive mem_en=0, mem_we=0, mem_wstrb=0, mem_wdata=0, mem_addr=0 outside ACC0/ACC1, and mem_we=0 and mem_wstrb=0 for loads.
REQ-014 SHALL meet these latencies, counted from the accept edge T: unsplit, rsp_valid in cycle T+2; split, rsp_valid in T+3; illegal, rsp_valid in T+1.
REQ-015 SHALL ignore req_* whenever req_ready=0.

Reset
REQ-016 SHALL, on a clock edge with rst=1, force state=IDLE and clear all latched request fields and word0.
REQ-017 SHALL hold outputs after reset at req_ready=1 and rsp_valid=0, rsp_err=0, rsp_rdata=0, with all mem_* outputs at 0.
REQ-018 SHALL let rst mid-operation abort the access with no rsp_valid; a memory write already issued is not rolled back; rst has priority over req_valid.

Verification
REQ-019 SHALL cover these directed scenarios:
- SW addr 0x100, wdata 0xDEADBEEF -> T+1: mem_en=1, mem_we=1, mem_addr=0x40, wstrb=1111, mem_wdata=0xDEADBEEF; T+2: rsp_valid=1, rsp_rdata=0.
- Word 0x40=0x80112233; LB addr 0x103 -> rsp_rdata=0xFFFFFF80 at T+2; LBU same -> 0x00000080.
- Words 0x40=0xAB000000, 0x41=0x000000CD; LH addr 0x103 -> mem_addr 0x40 then 0x41, rsp_rdata=0xFFFFCDAB at T+3.
- SW addr 0x102, wdata 0x11223344 -> ACC0: addr 0x40, wstrb=1100, wdata=0x33440000; ACC1: addr 0x41, wstrb=0011, wdata=0x00001122.
- LHU addr 0x3FFFFFF (MEM_AW=24) -> second access mem_addr=0x000000 (wrap); load with func3=011 -> no mem_en, rsp_valid and rsp_err=1 at T+1.
- rst=1 during ACC1 of a split load -> next cycle IDLE, req_ready=1, no rsp_valid; a new LW is then served normally.
